// File: rtl/csa_mult_pkg.sv
// Shared types and constants for the sequential carry-save mantissa multiplier.
//   state_t : controller states
//   MANT_W  : default mantissa width (hidden bit included)
package csa_mult_pkg;

    localparam int MANT_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

endpackage

// File: rtl/csa_seq_mult_if.sv
// Operand/result handshake bundle for csa_seq_mult.
//   in_valid/in_ready/a/b    : operand channel (master drives operands)
//   out_valid/out_ready/p    : result channel (slave drives product)
//   flush                    : synchronous abort from master
//   busy                     : slave is accumulating or resolving
interface csa_seq_mult_if
    import csa_mult_pkg::*;
#(
    parameter int W = MANT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   p;
    logic             busy;

    modport master (
        output in_valid, a, b, flush, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, flush, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/csa_row.sv
// One row of independent full adders: three N-bit vectors in, a sum vector
// and a carry vector out. c_out[i] carries weight 2^(i+1).
//   c_in, a, b : addends
//   s          : bitwise sum
//   c_out      : bitwise carry (unshifted)
module csa_row #(
    parameter int N = 25
) (
    input  logic [N-1:0] c_in,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic [N-1:0] c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: rtl/csa_seq_mult.sv
// Sequential W x W unsigned multiplier: one multiplier bit per cycle is
// folded into a redundant sum/carry accumulator through a single CSA row,
// then one carry-propagate add forms the upper half of the product.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result handshake, flush and busy (slave side)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for operands, in_ready high
// ACCUM   | W cycles, one partial product retired per cycle
// RESOLVE | one cycle, S + C carry-propagate add, product registered
// DONE    | product valid and held until out_ready
module csa_seq_mult
    import csa_mult_pkg::*;
#(
    parameter int W = MANT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    csa_seq_mult_if.slave bus
);
    localparam int CW = $clog2(W);

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_sr;
    logic [W-1:0]    s_q;
    logic [W-1:0]    c_q;
    logic [W-1:0]    low_q;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  p_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [W-1:0]    pp;
    logic [W:0]      row_s;
    logic [W:0]      row_c;
    logic [W:0]      high;
    logic            msb_unused;

    assign pp = b_sr[0] ? a_q : '0;

    csa_row #(.N(W + 1)) u_row (
        .c_in  ({1'b0, c_q}),
        .a     ({1'b0, s_q}),
        .b     ({1'b0, pp}),
        .s     (row_s),
        .c_out (row_c)
    );

    assign high = {1'b0, s_q} + {1'b0, c_q};

    // Both MSBs are zero by construction: the row's top column has three
    // zero inputs, and the upper product half always fits in W bits.
    assign msb_unused = row_c[W] | high[W];

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_sr        <= '0;
            s_q         <= '0;
            c_q         <= '0;
            low_q       <= '0;
            cnt         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.a;
                        b_sr   <= bus.b;
                        s_q    <= '0;
                        c_q    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        // Sum drops its retired LSB; carry is already one
                        // position left of the sum, so it lands unshifted.
                        s_q   <= row_s[W:1];
                        c_q   <= row_c[W-1:0];
                        low_q <= {row_s[0], low_q[W-1:1]};
                        b_sr  <= b_sr >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(W - 1)) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    busy_q <= 1'b0;
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        p_q         <= {high[W-1:0], low_q};
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.flush) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_q    <= bus.a;
                            b_sr   <= bus.b;
                            s_q    <= '0;
                            c_q    <= '0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_seq_mult.sv
// Self-checking bench for csa_seq_mult: directed scenarios followed by a
// randomized sweep, all products checked against plain a*b.
module tb_csa_seq_mult;
    import csa_mult_pkg::*;

    localparam int W   = MANT_W;
    localparam int LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_seq_mult_if #(.W(W)) bus ();

    csa_seq_mult #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx;
        logic [2*W-1:0] yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Present operands and complete the handshake; returns just after the accept edge.
    task automatic accept(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.in_ready; i++) tick();
        check({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to out_valid, then check latency and product.
    task automatic await_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                input bit chk_busy);
        int k;
        k = 0;
        while (!bus.out_valid && k < 200) begin
            if (chk_busy) begin
                check({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
                check({tag, "_busy_high"}, 64'(bus.busy), 64'd1);
            end
            tick();
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(LAT));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_p"}, 64'(bus.p), 64'(ref_mul(x, y)));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit chk_busy);
        bus.out_ready = 1'b1;
        accept(tag, x, y);
        await_result(tag, x, y, chk_busy);
        tick();
        check({tag, "_valid_one_cycle"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]    r0;
        logic [31:0]    r1;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] exp_p;
        int             seen;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // reset values
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_p", 64'(bus.p), 64'd0);
        #5 rst_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // corner operands
        run_op("ones", {W{1'b1}}, {W{1'b1}}, 1'b1);
        check("ones_const", 64'(bus.p), 64'h0000FFFFFE000001);
        run_op("msb", 24'h800000, 24'h800000, 1'b1);
        run_op("zero_a", 24'h000000, 24'h123456, 1'b1);

        // back-to-back with in_valid held: second accept rides the first result's retire edge
        bus.out_ready = 1'b1;
        accept("b2b_1", 24'd3, 24'd5);
        bus.a        = 24'd7;
        bus.b        = 24'd9;
        bus.in_valid = 1'b1;
        await_result("b2b_1", 24'd3, 24'd5, 1'b1);
        check("b2b_done_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_valid_drop", 64'(bus.out_valid), 64'd0);
        await_result("b2b_2", 24'd7, 24'd9, 1'b1);
        tick();
        check("b2b_2_valid_one_cycle", 64'(bus.out_valid), 64'd0);

        // backpressure: result held while out_ready low
        bus.out_ready = 1'b0;
        accept("bp", 24'hABCDEF, 24'h000002);
        await_result("bp", 24'hABCDEF, 24'h000002, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_p", 64'(bus.p), 64'(ref_mul(24'hABCDEF, 24'h000002)));
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_follows", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp_retired", 64'(bus.out_valid), 64'd0);
        check("bp_idle_ready", 64'(bus.in_ready), 64'd1);

        // flush during the 10th accumulation cycle
        accept("flush_acc", 24'h5A5A5A, 24'hC3C3C3);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_acc_busy", 64'(bus.busy), 64'd0);
        check("flush_acc_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_acc_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        repeat (30) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("flush_acc_no_result", 64'(seen), 64'd0);
        run_op("after_flush", 24'd2, 24'd3, 1'b1);

        // flush in DONE wins over a same-cycle accept
        bus.out_ready = 1'b0;
        accept("flush_done", 24'h00F00F, 24'h000111);
        await_result("flush_done", 24'h00F00F, 24'h000111, 1'b0);
        bus.a         = 24'd11;
        bus.b         = 24'd13;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_done_valid", 64'(bus.out_valid), 64'd0);
        check("flush_done_busy", 64'(bus.busy), 64'd0);
        check("flush_done_in_ready", 64'(bus.in_ready), 64'd1);

        // asynchronous reset in the middle of accumulation
        accept("mid_rst", 24'h13579B, 24'h2468AC);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_p", 64'(bus.p), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        run_op("post_rst", 24'h000FFF, 24'h000FFF, 1'b1);

        // randomized sweep with random result backpressure
        for (int n = 0; n < 300; n++) begin
            r0 = $urandom;
            r1 = $urandom;
            x  = r0[W-1:0];
            y  = r1[W-1:0];
            case ($urandom_range(0, 7))
                0: x = '0;
                1: y = {W{1'b1}};
                2: x = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            exp_p = ref_mul(x, y);
            bus.out_ready = 1'b1;
            accept("rnd", x, y);
            await_result("rnd", x, y, 1'b0);
            bus.out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("rnd_hold_p", 64'(bus.p), 64'(exp_p));
            end
            bus.out_ready = 1'b1;
            tick();
            check("rnd_retired", 64'(bus.out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
